// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - shares one single-port BRAM between a priority reader and a starvation-bounded writer
module bram_port_arbiter #(
    parameter int  RAM_WIDTH   = 18,
    parameter int  RAM_DEPTH   = 1024,
    parameter int  MAX_WR_WAIT = 8,
    localparam int ADDR_W      = $clog2(RAM_DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 rd_req_i,
    input  logic [ADDR_W-1:0]    rd_addr_i,
    output logic                 rd_gnt_o,
    output logic                 rd_valid_o,
    output logic [RAM_WIDTH-1:0] rd_data_o,
    input  logic                 wr_req_i,
    input  logic [ADDR_W-1:0]    wr_addr_i,
    input  logic [RAM_WIDTH-1:0] wr_data_i,
    output logic                 wr_gnt_o,
    output logic                 ram_en_o,
    output logic                 ram_we_o,
    output logic [ADDR_W-1:0]    ram_addr_o,
    output logic [RAM_WIDTH-1:0] ram_din_o,
    input  logic [RAM_WIDTH-1:0] ram_dout_i
);
    localparam logic [7:0] MAX_WAIT = 8'(MAX_WR_WAIT);

    logic [7:0] wait_cnt;
    logic       force_wr;
    logic       rd_s1;

    // Reads win unless the pending write has already been blocked MAX_WR_WAIT cycles.
    assign force_wr   = wr_req_i && (wait_cnt >= MAX_WAIT);
    assign wr_gnt_o   = rstn_i && wr_req_i && (!rd_req_i || force_wr);
    assign rd_gnt_o   = rstn_i && rd_req_i && !wr_gnt_o;

    assign ram_en_o   = rd_gnt_o || wr_gnt_o;
    assign ram_we_o   = wr_gnt_o;
    assign ram_addr_o = wr_gnt_o ? wr_addr_i : rd_addr_i;
    assign ram_din_o  = wr_data_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wait_cnt <= '0;
        end else if (wr_gnt_o || !wr_req_i) begin
            wait_cnt <= '0;
        end else if (wait_cnt != 8'hFF) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Stage 1 marks the cycle the RAM presents read data; stage 2 registers it.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_s1      <= 1'b0;
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
        end else begin
            rd_s1      <= rd_gnt_o;
            rd_valid_o <= rd_s1;
            if (rd_s1) begin
                rd_data_o <= ram_dout_i;
            end
        end
    end
endmodule
